// File: rtl/fp_pkg.sv
// fp_pkg: shared widths and the stage-1 register layout for the FP alignment pipeline
package fp_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 24;
  localparam int SH_W = 5;
  localparam int GRS_W = 2;
  typedef struct packed {
    logic [EXP_W-1:0] big_exp;
    logic [MAN_W-1:0] big_man;
    logic [MAN_W-1:0] sml_man;
    logic [SH_W-1:0]  shamt;
    logic             swapped;
  } align_s1_t;
endpackage

// File: rtl/fp_shiftright_stage.sv
// fp_shiftright_stage: conditional right shift by constant N, folding shifted-out bits into sticky
// Sticky accumulation only exists when FP_ALIGN_STICKY_EN is defined; otherwise sticky passes through.
module fp_shiftright_stage #(
  parameter int W = 26,
  parameter int N = 1
) (
  input  logic         i_en,
  input  logic [W-1:0] i_man,
  input  logic         i_sticky,
  output logic [W-1:0] o_man,
  output logic         o_sticky
);
  assign o_man = i_en ? i_man >> N : i_man;
`ifdef FP_ALIGN_STICKY_EN
  assign o_sticky = i_sticky | (i_en & |i_man[N-1:0]);
`else
  assign o_sticky = i_sticky;
`endif
endmodule

// File: rtl/fp_align_shiftright.sv
// fp_align_shiftright: 2-stage compare/swap + right-shift exponent alignment with valid/ready
// Optional sticky generation is enabled by defining FP_ALIGN_STICKY_EN.
module fp_align_shiftright
  import fp_pkg::*;
#(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int MAN_W = fp_pkg::MAN_W,
  parameter int SH_W  = fp_pkg::SH_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W-1:0]       exp_a,
  input  logic [MAN_W-1:0]       man_a,
  input  logic [EXP_W-1:0]       exp_b,
  input  logic [MAN_W-1:0]       man_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W-1:0]       exp_out,
  output logic [MAN_W+GRS_W-1:0] man_big,
  output logic [MAN_W+GRS_W-1:0] man_sml,
  output logic                   sticky,
  output logic                   swapped
);
  localparam int VW = MAN_W + GRS_W;
  align_s1_t r_s1, w_s1;
  logic r_s1_valid, r_s2_valid, w_s2_load, w_a_big, w_big_sh, w_sticky;
  logic [EXP_W-1:0] w_diff;
  logic [VW-1:0] w_man [SH_W+1];
  logic [SH_W:0] w_st;
  logic [VW-1:0] w_sml;
  assign w_s2_load = !r_s2_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_load;
  assign out_valid = r_s2_valid;
  always_comb begin
    w_a_big = exp_a > exp_b || (exp_a == exp_b && man_a >= man_b);
    w_s1.swapped = !w_a_big;
    w_s1.big_exp = w_a_big ? exp_a : exp_b;
    w_s1.big_man = w_a_big ? man_a : man_b;
    w_s1.sml_man = w_a_big ? man_b : man_a;
    w_diff = w_s1.big_exp - (w_a_big ? exp_b : exp_a);
    w_s1.shamt = |w_diff[EXP_W-1:SH_W] ? '1 : w_diff[SH_W-1:0];
  end
  assign w_man[0] = {r_s1.sml_man, {GRS_W{1'b0}}};
  assign w_st[0] = 1'b0;
  for (genvar g = 0; g < SH_W; g++) begin : g_sh
    fp_shiftright_stage #(.W(VW), .N(1 << (SH_W - 1 - g))) u_stage (
      .i_en(r_s1.shamt[SH_W-1-g]),
      .i_man(w_man[g]),
      .i_sticky(w_st[g]),
      .o_man(w_man[g+1]),
      .o_sticky(w_st[g+1])
    );
  end
  // shifts at or beyond the full vector width flush everything into sticky
  assign w_big_sh = r_s1.shamt >= SH_W'(VW);
  assign w_sml = w_big_sh ? '0 : w_man[SH_W];
`ifdef FP_ALIGN_STICKY_EN
  assign w_sticky = (w_big_sh & |r_s1.sml_man) | w_st[SH_W];
`else
  assign w_sticky = w_st[SH_W];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s1 <= '0;
      exp_out <= '0;
      man_big <= '0;
      man_sml <= '0;
      sticky <= 1'b0;
      swapped <= 1'b0;
    end else begin
      if (in_ready) r_s1_valid <= in_valid;
      if (in_ready && in_valid) r_s1 <= w_s1;
      if (w_s2_load) r_s2_valid <= r_s1_valid;
      if (w_s2_load && r_s1_valid) begin
        exp_out <= r_s1.big_exp;
        man_big <= {r_s1.big_man, {GRS_W{1'b0}}};
        man_sml <= w_sml;
        sticky <= w_sticky;
        swapped <= r_s1.swapped;
      end
    end
  end
endmodule

// File: tb/tb_fp_align_shiftright.sv
// tb_fp_align_shiftright: randomized and directed checks against an arithmetic alignment model
module tb_fp_align_shiftright;
  typedef logic [61:0] res_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, sticky, swapped;
  logic [7:0] exp_a = 0, exp_b = 0, exp_out;
  logic [23:0] man_a = 0, man_b = 0;
  logic [25:0] man_big, man_sml;
  int n_checks = 0, n_fail = 0;
  res_t exp_q[$], got_q[$];

  always #5 clk = ~clk;

  fp_align_shiftright dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .exp_a(exp_a), .man_a(man_a), .exp_b(exp_b), .man_b(man_b),
    .out_valid(out_valid), .out_ready(out_ready), .exp_out(exp_out),
    .man_big(man_big), .man_sml(man_sml), .sticky(sticky), .swapped(swapped)
  );

  function automatic res_t model(logic [7:0] ea, logic [23:0] ma, logic [7:0] eb, logic [23:0] mb);
    bit a_big, st;
    int be, se, sh;
    longint bm, sm, v, sml;
    a_big = ea > eb || (ea == eb && ma >= mb);
    be = a_big ? int'(ea) : int'(eb);
    se = a_big ? int'(eb) : int'(ea);
    bm = a_big ? longint'(ma) : longint'(mb);
    sm = a_big ? longint'(mb) : longint'(ma);
    sh = be - se;
    if (sh > 31) sh = 31;
    v = sm * 4;
    if (sh >= 26) begin
      sml = 0;
      st = sm != 0;
    end else begin
      sml = v >> sh;
      st = (v % (longint'(1) << sh)) != 0;
    end
`ifndef FP_ALIGN_STICKY_EN
    st = 0;
`endif
    return {8'(be), 26'(bm * 4), 26'(sml), st, !a_big};
  endfunction

  task automatic tick();
    #1;
    if (!rst && in_valid && in_ready) exp_q.push_back(model(exp_a, man_a, exp_b, man_b));
    if (!rst && out_valid && out_ready) got_q.push_back({exp_out, man_big, man_sml, sticky, swapped});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(output bit ok);
    for (int i = 0; i < 50 && got_q.size() < exp_q.size(); i++) tick();
    ok = got_q.size() == exp_q.size();
  endtask

  task automatic gen_pair();
    exp_a = 8'($urandom_range(1, 254));
    exp_b = ($urandom % 2) ? 8'(exp_a + $urandom_range(0, 30) - 15) : 8'($urandom);
    man_a = 24'h800000 | 24'($urandom);
    man_b = ($urandom % 10 == 0) ? man_a : (24'h800000 | 24'($urandom));
    if ($urandom % 4 == 0) man_b[15:0] = 16'h0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if ({exp_out, man_big, man_sml, sticky, swapped} !== 62'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {exp_out, man_big, man_sml, sticky, swapped});
    end
    rst = 0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [7:0] ea [7] = '{8'h82, 8'h7F, 8'h7D, 8'h90, 8'h85, 8'h85, 8'hFF};
    logic [23:0] ma [7] = '{24'hC00000, 24'h800001, 24'h800001, 24'hC00000, 24'h900000, 24'hA00000, 24'hFFFFFF};
    logic [7:0] eb [7] = '{8'h80, 8'h80, 8'h80, 8'h70, 8'h85, 8'h85, 8'h00};
    logic [23:0] mb [7] = '{24'h800000, 24'h800000, 24'h800000, 24'h800000, 24'hA00000, 24'hA00000, 24'hFFFFFF};
    res_t g, e;
    out_ready = 1;
    for (int i = 0; i < 7; i++) begin
      exp_a = ea[i]; man_a = ma[i]; exp_b = eb[i]; man_b = mb[i];
      in_valid = 1;
      tick();
      in_valid = 0;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early[%0d]: got %b expected 0", i, out_valid); end
      tick();
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_2[%0d]: got %b expected 1", i, out_valid); end
      tick();
      n_checks++;
      if (got_q.size() != 1 || exp_q.size() != 1) begin
        n_fail++; $display("FAIL directed_count[%0d]: got %0d expected 1", i, got_q.size());
        got_q.delete(); exp_q.delete();
      end else begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL directed[%0d]: got %h expected %h", i, g, e); end
        if (i == 0) begin
          n_checks++;
          if (g !== {8'h82, 26'h3000000, 26'h0800000, 1'b0, 1'b0}) begin n_fail++; $display("FAIL plan_shift2: got %h expected %h", g, {8'h82, 26'h3000000, 26'h0800000, 1'b0, 1'b0}); end
        end
        if (i == 4) begin
          n_checks++;
          if (g !== {8'h85, 26'h2800000, 26'h2400000, 1'b0, 1'b1}) begin n_fail++; $display("FAIL plan_equal_exp: got %h expected %h", g, {8'h85, 26'h2800000, 26'h2400000, 1'b0, 1'b1}); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    bit ok;
    res_t g, e;
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      gen_pair();
      in_valid = 1;
      #1;
      if (!in_ready) stalls++;
      tick();
    end
    in_valid = 0;
    n_checks++;
    if (stalls != 0) begin n_fail++; $display("FAIL b2b_stalls: got %0d expected 0", stalls); end
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b2b_drain: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    logic [7:0] ea [3], eb [3];
    logic [23:0] ma [3], mb [3];
    res_t snap, g, e;
    bit have_snap = 0, acc, ok;
    int idx = 0, n_out = 0;
    for (int i = 0; i < 3; i++) begin
      gen_pair();
      ea[i] = exp_a; ma[i] = man_a; eb[i] = exp_b; mb[i] = man_b;
    end
    out_ready = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1;
      exp_a = ea[idx]; man_a = ma[idx]; exp_b = eb[idx]; man_b = mb[idx];
      #1;
      acc = in_ready;
      if (out_valid && !have_snap) begin
        snap = {exp_out, man_big, man_sml, sticky, swapped};
        have_snap = 1;
      end else if (have_snap) begin
        n_checks++;
        if ({exp_out, man_big, man_sml, sticky, swapped} !== snap || !out_valid) begin
          n_fail++; $display("FAIL hold_stable: got %h expected %h", {exp_out, man_big, man_sml, sticky, swapped}, snap);
        end
      end
      tick();
      if (acc) idx++;
    end
    n_checks++;
    if (idx != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 2", idx); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    out_ready = 1;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      in_valid = 1;
      exp_a = ea[idx]; man_a = ma[idx]; exp_b = eb[idx]; man_b = mb[idx];
      #1;
      acc = in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 0;
    drain(ok);
    n_checks++;
    if (!ok || exp_q.size() != 3) begin n_fail++; $display("FAIL bp_drain: got %0d expected 3", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", n_out, g, e); end
      n_out++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    int sent = 0, total = 300;
    bit last_acc = 0, ok;
    res_t g, e;
    for (int c = 0; c < 5000 && sent < total; c++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid = ($urandom % 4 != 0);
        if (in_valid) gen_pair();
      end
      out_ready = ($urandom % 10 < 7);
      #1;
      last_acc = in_valid && in_ready;
      if (last_acc) sent++;
      tick();
    end
    in_valid = 0;
    out_ready = 1;
    drain(ok);
    n_checks++;
    if (!ok || exp_q.size() != total) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), total); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL rand_data: got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      gen_pair();
      in_valid = 1;
      tick();
    end
    in_valid = 0;
    n_checks++;
    if (!(out_valid === 1'b1 && in_ready === 1'b0)) begin
      n_fail++; $display("FAIL mid_full: got out_valid=%b in_ready=%b expected 1 0", out_valid, in_ready);
    end
    rst = 1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b expected 0", out_valid); end
    rst = 0;
    exp_q.delete(); got_q.delete();
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (out_valid) seen++;
      tick();
    end
    n_checks++;
    if (seen != 0 || got_q.size() != 0) begin n_fail++; $display("FAIL mid_stale: got %0d expected 0", seen); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
